// File: rtl/risac_bus_arbiter_if.sv
// Bus bundle between the risac core (ibus/dbus), the arbiter and the unified memory.
// slave = arbiter view, master = surrounding core/memory view.
interface risac_bus_arbiter_if;
  logic [31:0] iIbusAddr;
  logic        iIbusRead;
  logic [31:0] oIbusData;
  logic [31:0] oIbusIAddr;
  logic        oIbusWait;
  logic [31:0] iDbusAddr;
  logic        iDbusRead;
  logic        iDbusWe;
  logic [31:0] iDbusData;
  logic [3:0]  iDbusByteEn;
  logic [31:0] oDbusData;
  logic        oDbusWait;
  logic [31:0] oMemAddr;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] oMemData;
  logic [3:0]  oMemByteEn;
  logic [31:0] iMemData;
  logic        iMemWait;
  logic        oBusErr;

  modport slave (
    input  iIbusAddr, iIbusRead, iDbusAddr, iDbusRead, iDbusWe, iDbusData, iDbusByteEn,
           iMemData, iMemWait,
    output oIbusData, oIbusIAddr, oIbusWait, oDbusData, oDbusWait,
           oMemAddr, oMemRead, oMemWrite, oMemData, oMemByteEn, oBusErr
  );

  modport master (
    output iIbusAddr, iIbusRead, iDbusAddr, iDbusRead, iDbusWe, iDbusData, iDbusByteEn,
           iMemData, iMemWait,
    input  oIbusData, oIbusIAddr, oIbusWait, oDbusData, oDbusWait,
           oMemAddr, oMemRead, oMemWrite, oMemData, oMemByteEn, oBusErr
  );
endinterface

// File: rtl/risac_bus_arbiter.sv
// Ibus/dbus arbiter for one single-ported memory; dbus priority with a consecutive-grant cap.
// Optional memory-wait watchdog enabled by defining RISAC_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer; select owner from current requests
// BUSY  | request held on the memory port until iMemWait drops
// RESP  | one cycle; owner's wait low, captured data stable
module risac_bus_arbiter #(
  parameter int DBUS_MAX_CONSEC = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic clk,
  input logic rst_n,
  risac_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, stateNext;
  logic        ownerD;
  logic [3:0]  dconsec;
  logic        ireq, dreq, dCapped;
  logic        grantD, grantI, finish, timeout;
  logic [31:0] memAddr, memData, ibusData, ibusIAddr, dbusData;
  logic [3:0]  memByteEn;
  logic        memRead, memWrite;

  assign ireq    = bus.iIbusRead;
  assign dreq    = bus.iDbusRead | bus.iDbusWe;
  assign dCapped = (dconsec == 4'(DBUS_MAX_CONSEC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && !(ireq && dCapped)) begin
          grantD    = 1'b1;
          stateNext = BUSY;
        end else if (ireq) begin
          grantI    = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (!bus.iMemWait || timeout) begin
          finish    = 1'b1;
          stateNext = RESP;
        end
      end
      // Requests are deliberately ignored here: the core still shows the finished one.
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ownerD    <= 1'b0;
      dconsec   <= 4'd0;
      memAddr   <= 32'd0;
      memData   <= 32'd0;
      memByteEn <= 4'd0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      ibusData  <= 32'd0;
      ibusIAddr <= 32'd0;
      dbusData  <= 32'd0;
    end else begin
      if (grantD) begin
        ownerD    <= 1'b1;
        memAddr   <= bus.iDbusAddr;
        memData   <= bus.iDbusData;
        memByteEn <= bus.iDbusByteEn;
        memWrite  <= bus.iDbusWe;
        memRead   <= ~bus.iDbusWe;
        dconsec   <= ireq ? dconsec + 4'd1 : 4'd0;
      end else if (grantI) begin
        ownerD    <= 1'b0;
        memAddr   <= bus.iIbusAddr;
        memByteEn <= 4'hF;
        memWrite  <= 1'b0;
        memRead   <= 1'b1;
        dconsec   <= 4'd0;
      end
      if (finish) begin
        memRead  <= 1'b0;
        memWrite <= 1'b0;
        if (timeout || memRead) begin
          if (ownerD) begin
            dbusData <= timeout ? 32'hDEADBEEF : bus.iMemData;
          end else begin
            ibusData  <= timeout ? 32'hDEADBEEF : bus.iMemData;
            ibusIAddr <= memAddr;
          end
        end
      end
    end
  end

`ifdef RISAC_ARB_TIMEOUT_EN
  logic [7:0] toCnt;
  logic       busErr;

  // Abort on the TIMEOUT_CYCLES-th consecutive wait cycle of a transfer.
  assign timeout = (state == BUSY) & bus.iMemWait & (toCnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt  <= 8'd0;
      busErr <= 1'b0;
    end else begin
      if (grantD || grantI)                   toCnt <= 8'd0;
      else if (state == BUSY && bus.iMemWait) toCnt <= toCnt + 8'd1;
      if (timeout) busErr <= 1'b1;
    end
  end

  assign bus.oBusErr = busErr;
`else
  assign timeout     = 1'b0;
  assign bus.oBusErr = 1'b0;
`endif

  assign bus.oMemAddr   = memAddr;
  assign bus.oMemData   = memData;
  assign bus.oMemByteEn = memByteEn;
  assign bus.oMemRead   = memRead;
  assign bus.oMemWrite  = memWrite;
  assign bus.oIbusData  = ibusData;
  assign bus.oIbusIAddr = ibusIAddr;
  assign bus.oDbusData  = dbusData;
  assign bus.oIbusWait  = ~((state == RESP) & ~ownerD);
  assign bus.oDbusWait  = dreq & ~((state == RESP) & ownerD);

endmodule

// File: tb/tb_risac_bus_arbiter.sv
// Directed bench for risac_bus_arbiter; a small memory responder supplies wait states and data.
// Timeout checks are built only when RISAC_ARB_TIMEOUT_EN is defined.
module tb_risac_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  risac_bus_arbiter_if bus();

  risac_bus_arbiter #(.DBUS_MAX_CONSEC(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int          testsRun = 0;
  int          testsFailed = 0;
  int          memWait = 0;
  int          waitCnt = 0;
  logic        memHold = 1'b0;
  logic [31:0] memRdData = 32'd0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory model: reacts just after each edge to the registered strobes.
  initial begin
    bus.iMemWait = 1'b0;
    bus.iMemData = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.oMemRead || bus.oMemWrite) begin
        if (memHold || waitCnt < memWait) begin
          bus.iMemWait = 1'b1;
          waitCnt++;
        end else begin
          bus.iMemWait = 1'b0;
        end
        bus.iMemData = memRdData;
      end else begin
        bus.iMemWait = 1'b0;
        waitCnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] seq;
    int         nGrant, iResp, dResp, badIWait;
    logic       prevRd, lastOwnerD;

    bus.iIbusAddr = 0; bus.iIbusRead = 0;
    bus.iDbusAddr = 0; bus.iDbusRead = 0; bus.iDbusWe = 0;
    bus.iDbusData = 0; bus.iDbusByteEn = 0;

    // Reset values
    cyc(2);
    checkVal("rst_memRead",  32'(bus.oMemRead),  32'd0);
    checkVal("rst_memWrite", 32'(bus.oMemWrite), 32'd0);
    checkVal("rst_ibusWait", 32'(bus.oIbusWait), 32'd1);
    checkVal("rst_dbusWait", 32'(bus.oDbusWait), 32'd0);
    checkVal("rst_busErr",   32'(bus.oBusErr),   32'd0);
    checkVal("rst_memAddr",  bus.oMemAddr,  32'd0);
    checkVal("rst_memBe",    32'(bus.oMemByteEn), 32'd0);
    checkVal("rst_ibusData", bus.oIbusData, 32'd0);
    checkVal("rst_dbusData", bus.oDbusData, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Ibus-only fetch, zero wait
    memWait = 0; memRdData = 32'h00500093;
    bus.iIbusAddr = 32'h10; bus.iIbusRead = 1'b1;
    cyc(1);
    checkVal("if_c1_memRead",  32'(bus.oMemRead),  32'd1);
    checkVal("if_c1_memWrite", 32'(bus.oMemWrite), 32'd0);
    checkVal("if_c1_memAddr",  bus.oMemAddr, 32'h10);
    checkVal("if_c1_memBe",    32'(bus.oMemByteEn), 32'hF);
    checkVal("if_c1_ibusWait", 32'(bus.oIbusWait), 32'd1);
    cyc(1);
    checkVal("if_c2_ibusWait", 32'(bus.oIbusWait), 32'd0);
    checkVal("if_c2_ibusData", bus.oIbusData, 32'h00500093);
    checkVal("if_c2_ibusAddr", bus.oIbusIAddr, 32'h10);
    checkVal("if_c2_memRead",  32'(bus.oMemRead), 32'd0);
    bus.iIbusRead = 1'b0;
    cyc(1);
    checkVal("if_c3_ibusWait", 32'(bus.oIbusWait), 32'd1);
    checkVal("if_c3_ibusHold", bus.oIbusData, 32'h00500093);
    checkVal("if_c3_memRead",  32'(bus.oMemRead), 32'd0);

    // Simultaneous requests: dbus load with 2 wait states wins, then ibus
    memWait = 2; memRdData = 32'hCAFEF00D;
    bus.iIbusAddr = 32'h20; bus.iIbusRead = 1'b1;
    bus.iDbusAddr = 32'h200; bus.iDbusRead = 1'b1;
    cyc(1);
    checkVal("sim_c1_memAddr",  bus.oMemAddr, 32'h200);
    checkVal("sim_c1_memRead",  32'(bus.oMemRead), 32'd1);
    checkVal("sim_c1_dbusWait", 32'(bus.oDbusWait), 32'd1);
    cyc(2);
    checkVal("sim_c3_memRead",  32'(bus.oMemRead), 32'd1);
    checkVal("sim_c3_dbusWait", 32'(bus.oDbusWait), 32'd1);
    cyc(1);
    checkVal("sim_c4_dbusWait", 32'(bus.oDbusWait), 32'd0);
    checkVal("sim_c4_dbusData", bus.oDbusData, 32'hCAFEF00D);
    checkVal("sim_c4_ibusWait", 32'(bus.oIbusWait), 32'd1);
    bus.iDbusRead = 1'b0;
    memWait = 0; memRdData = 32'h11111111;
    cyc(2);
    checkVal("sim_c6_memAddr", bus.oMemAddr, 32'h20);
    checkVal("sim_c6_memRead", 32'(bus.oMemRead), 32'd1);
    cyc(1);
    checkVal("sim_c7_ibusWait", 32'(bus.oIbusWait), 32'd0);
    checkVal("sim_c7_ibusData", bus.oIbusData, 32'h11111111);
    checkVal("sim_c7_ibusAddr", bus.oIbusIAddr, 32'h20);
    bus.iIbusRead = 1'b0;
    cyc(1);

    // Continuous contention: expect D,D,D,D,I,D,D,D,D,I
    memWait = 0; memRdData = 32'h0BADF00D;
    bus.iIbusAddr = 32'h100; bus.iIbusRead = 1'b1;
    bus.iDbusAddr = 32'h300; bus.iDbusRead = 1'b1;
    seq = '0; nGrant = 0; iResp = 0; dResp = 0; badIWait = 0;
    prevRd = 1'b0; lastOwnerD = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.oMemRead && !prevRd) begin
        lastOwnerD = (bus.oMemAddr == 32'h300);
        if (nGrant < 10) seq[nGrant] = lastOwnerD;
        nGrant++;
      end
      prevRd = bus.oMemRead;
      if (!bus.oIbusWait) begin
        iResp++;
        if (lastOwnerD) badIWait++;
      end
      if (!bus.oDbusWait) dResp++;
    end
    bus.iIbusRead = 1'b0; bus.iDbusRead = 1'b0;
    checkVal("arb_grantSeq", 32'(seq), 32'h1EF);
    checkVal("arb_nGrant",   32'(nGrant), 32'd10);
    checkVal("arb_iResp",    32'(iResp), 32'd2);
    checkVal("arb_dResp",    32'(dResp), 32'd8);
    checkVal("arb_badIWait", 32'(badIWait), 32'd0);
    checkVal("arb_ibusData", bus.oIbusData, 32'h0BADF00D);
    cyc(1);

    // Store with read also high: treated as a write, oDbusData untouched
    bus.iDbusAddr = 32'h40; bus.iDbusData = 32'h12345678; bus.iDbusByteEn = 4'b0011;
    bus.iDbusWe = 1'b1; bus.iDbusRead = 1'b1;
    cyc(1);
    checkVal("st_c1_memWrite", 32'(bus.oMemWrite), 32'd1);
    checkVal("st_c1_memRead",  32'(bus.oMemRead), 32'd0);
    checkVal("st_c1_memAddr",  bus.oMemAddr, 32'h40);
    checkVal("st_c1_memData",  bus.oMemData, 32'h12345678);
    checkVal("st_c1_memBe",    32'(bus.oMemByteEn), 32'h3);
    cyc(1);
    checkVal("st_c2_memWrite", 32'(bus.oMemWrite), 32'd0);
    checkVal("st_c2_dbusWait", 32'(bus.oDbusWait), 32'd0);
    checkVal("st_c2_ibusWait", 32'(bus.oIbusWait), 32'd1);
    checkVal("st_c2_dbusData", bus.oDbusData, 32'h0BADF00D);
    bus.iDbusWe = 1'b0; bus.iDbusRead = 1'b0;
    cyc(1);

`ifdef RISAC_ARB_TIMEOUT_EN
    // Watchdog: memory never answers, abort after 8 wait cycles
    memHold = 1'b1;
    bus.iDbusAddr = 32'h44; bus.iDbusRead = 1'b1;
    cyc(8);
    checkVal("to_c8_memRead",  32'(bus.oMemRead), 32'd1);
    checkVal("to_c8_dbusWait", 32'(bus.oDbusWait), 32'd1);
    checkVal("to_c8_busErr",   32'(bus.oBusErr), 32'd0);
    cyc(1);
    checkVal("to_c9_dbusWait", 32'(bus.oDbusWait), 32'd0);
    checkVal("to_c9_dbusData", bus.oDbusData, 32'hDEADBEEF);
    checkVal("to_c9_busErr",   32'(bus.oBusErr), 32'd1);
    checkVal("to_c9_memRead",  32'(bus.oMemRead), 32'd0);
    bus.iDbusRead = 1'b0; memHold = 1'b0;
    cyc(2);
    checkVal("to_sticky_busErr", 32'(bus.oBusErr), 32'd1);
`else
    checkVal("noTo_busErr", 32'(bus.oBusErr), 32'd0);
`endif

    // Async reset while stalled in BUSY, then a clean fetch from 0x0
    memHold = 1'b1;
    bus.iIbusAddr = 32'h80; bus.iIbusRead = 1'b1;
    cyc(3);
    checkVal("rb_c3_memRead", 32'(bus.oMemRead), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("rb_memRead",  32'(bus.oMemRead), 32'd0);
    checkVal("rb_ibusWait", 32'(bus.oIbusWait), 32'd1);
    checkVal("rb_memAddr",  bus.oMemAddr, 32'd0);
    checkVal("rb_ibusData", bus.oIbusData, 32'd0);
    checkVal("rb_busErr",   32'(bus.oBusErr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; memHold = 1'b0; memWait = 0; memRdData = 32'hABCD0001;
    bus.iIbusAddr = 32'h0;
    cyc(1);
    checkVal("ra_c1_memRead", 32'(bus.oMemRead), 32'd1);
    checkVal("ra_c1_memAddr", bus.oMemAddr, 32'h0);
    cyc(1);
    checkVal("ra_c2_ibusWait", 32'(bus.oIbusWait), 32'd0);
    checkVal("ra_c2_ibusData", bus.oIbusData, 32'hABCD0001);
    checkVal("ra_c2_ibusAddr", bus.oIbusIAddr, 32'h0);
    bus.iIbusRead = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
